pipe_phy_stub: RTL and testbench
================================

PIPE_PHY_STUB -- requirements
Module: pipe_phy_stub

Interface
REQ-001 SHALL take parameters (name, default, meaning): MAXPIPEWIDTH, 32, max PIPE data width per lane in bits.
REQ-002 SHALL take LANESNUMBER, 16, lane count.
REQ-003 SHALL take DETECT_LATENCY, 16, cycles from detect start to result (range 2..255).
REQ-004 SHALL take PWR_LATENCY, 4, cycles from PowerDown change to PhyStatus (range 1..255).
REQ-005 SHALL take RATE_LATENCY, 8, cycles from Rate change to PhyStatus (range 1..255).
REQ-006 SHALL take RX_PRESENT_MASK, all ones (LANESNUMBER bits), lanes reporting a receiver present.
REQ-007 SHALL have ports (name, direction, width, meaning): CLK, in, 1, the only clock; reset, in, 1, synchronous, active-high.
REQ-008 TxData, in, MAXPIPEWIDTH*LANESNUMBER, controller transmit data.
REQ-009 TxDataValid, in, LANESNUMBER; TxDataK, in, (MAXPIPEWIDTH/8)*LANESNUMBER; TxElecIdle, in, LANESNUMBER; TxDetectRx_Loopback, in, LANESNUMBER.
REQ-010 PowerDown, in, 4*LANESNUMBER; Rate, in, 4, rate request.
REQ-011 RxData, out, MAXPIPEWIDTH*LANESNUMBER; RxDataValid, out, LANESNUMBER; RxDataK, out, (MAXPIPEWIDTH/8)*LANESNUMBER; RxValid, out, LANESNUMBER.
REQ-012 RxStatus, out, 3*LANESNUMBER; RxElectricalIdle, out, LANESNUMBER; PhyStatus, out, LANESNUMBER.

Function
REQ-013 SHALL run one control FSM shared by all lanes, states IDLE, DETECT_WAIT, DETECT_DONE, DETECT_HOLD, PWR_WAIT, RATE_WAIT.
REQ-014 IDLE->DETECT_WAIT when any TxDetectRx_Loopback bit =1, all TxElecIdle =1, and lane-0 PowerDown = 4'b0010 (P1); counter loads DETECT_LATENCY-1.
REQ-015 DETECT_WAIT decrements each cycle; at 0 goes to DETECT_DONE.
REQ-016 DETECT_DONE lasts exactly one cycle: PhyStatus = all ones; RxStatus lane i = 3'b011 if RX_PRESENT_MASK[i], else 3'b000; next state DETECT_HOLD.
REQ-017 DETECT_HOLD stays until all TxDetectRx_Loopback bits =0, then goes to IDLE; PhyStatus =0 and RxStatus =0 throughout.
REQ-018 A registered copy of PowerDown and Rate is kept; a mismatch with the current input sets a pending flag (pwr_pend, rate_pend) and updates the copy in the same cycle.
REQ-019 IDLE with pwr_pend -> PWR_WAIT (counter PWR_LATENCY-1); at 0, one-cycle PhyStatus = all ones, clear pwr_pend, return to IDLE.
REQ-020 IDLE with rate_pend -> RATE_WAIT (counter RATE_LATENCY-1); same completion as REQ-019, clearing rate_pend.
REQ-021 Arbitration in IDLE: detect > power > rate; unserved requests stay pending; a change arriving during any wait state is latched and served afterwards, never dropped, never merged into the current pulse.
REQ-022 PhyStatus SHALL be high only for the single completion cycle of each event; it is never asserted on back-to-back cycles.
REQ-023 Loopback data path, per lane i: when PowerDown lane i = 4'b0000 (P0) and TxElecIdle[i] =0, RxData, RxDataK, RxDataValid take TxData, TxDataK, TxDataValid with exactly 1 cycle of latency, and RxValid[i] =1.
REQ-024 Otherwise the lane's RxData, RxDataK, RxDataValid and RxValid =0 on the next cycle.
REQ-025 RxElectricalIdle[i] = TxElecIdle[i] delayed 1 cycle.
REQ-026 RxStatus SHALL be 0 in every cycle except DETECT_DONE.

Reset
REQ-027 While reset =1 at a CLK edge: state IDLE, counters 0, pending flags 0, PowerDown copy = 4'b0010 per lane, Rate copy = 0, all outputs 0 except RxElectricalIdle = all ones.
REQ-028 Reset mid-operation (any wait state) SHALL abort with no PhyStatus pulse; the first post-reset cycle starts in IDLE.

Structure
REQ-029 FSM state encoding, P0/P1 PowerDown codes, and RxStatus codes (3'b000 OK, 3'b011 receiver detected) SHALL live in a shared package.
REQ-030 A sub-module pipe_lane_loopback SHALL be used, one instance per lane, holding the REQ-023 to REQ-025 path; the FSM stays in the top.

Verification
REQ-031 Reset, then hold P1, TxElecIdle all ones, TxDetectRx_Loopback = 16'hFFFF -> PhyStatus = 16'hFFFF and RxStatus lanes = 3'b011 for one cycle, exactly 16 cycles after the request is sampled.
REQ-032 RX_PRESENT_MASK = 16'h00FF, same detect -> lanes 0-7 report 3'b011, lanes 8-15 report 3'b000.
REQ-033 PowerDown P1->P0 and Rate 0->1 on the same cycle -> PhyStatus pulse after 4 cycles, then a second pulse 8 cycles after the return to IDLE.
REQ-034 P0, TxElecIdle =0, TxData lane 0 = 32'hA5A5_0F0F with TxDataValid =1 -> RxData lane 0 = 32'hA5A5_0F0F and RxValid[0] =1 one cycle later.
REQ-035 Reset asserted in DETECT_WAIT at count 5 -> no PhyStatus pulse; re-request after release -> full 16-cycle detect sequence.

Source files
------------

// File: rtl/pipe_phy_stub_pkg.sv
// pipe_phy_stub_pkg
// Shared definitions for the PIPE PHY stub:
//   - control FSM state encoding
//   - PowerDown codes used by the stub (P0 active, P1 detect-capable)
//   - RxStatus codes (OK, receiver detected)
//   - counter width and a helper that turns a latency into a counter load
package pipe_phy_stub_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_DETECT_WAIT = 3'd1,
      ST_DETECT_DONE = 3'd2,
      ST_DETECT_HOLD = 3'd3,
      ST_PWR_WAIT    = 3'd4,
      ST_RATE_WAIT   = 3'd5
   } ctrl_state_t;

   localparam logic [3:0] PD_P0 = 4'b0000;
   localparam logic [3:0] PD_P1 = 4'b0010;

   localparam logic [2:0] RXST_OK     = 3'b000;
   localparam logic [2:0] RXST_RX_DET = 3'b011;

   // Latencies are limited to 1..255, so 8 bits always suffice.
   localparam int CNT_W = 8;

   // A wait of L cycles loads L-1: the cycle that observes zero is the last one.
   function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/pipe_phy_stub_lane.sv
// pipe_lane_loopback
// Per-lane loopback for the PIPE PHY stub. When the lane is in P0 and not
// electrically idle, transmit data/K/valid reappear on the receive side one
// cycle later with RxValid set; otherwise the receive side is zeroed.
// RxElectricalIdle is TxElecIdle delayed by one cycle.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_tx_data/k/valid   lane transmit data, K flags, data valid
//   i_tx_elec_idle      lane transmit electrical idle
//   i_power_down        lane PowerDown code
//   o_rx_data/k/valid   looped-back receive data, K flags, data valid
//   o_rx_valid          receive symbol lock indication
//   o_rx_elec_idle      receive electrical idle
module pipe_lane_loopback
   import pipe_phy_stub_pkg::*;
#(
   parameter int W = 32
)(
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [W-1:0]    i_tx_data,
   input  logic [W/8-1:0]  i_tx_k,
   input  logic            i_tx_valid,
   input  logic            i_tx_elec_idle,
   input  logic [3:0]      i_power_down,
   output logic [W-1:0]    o_rx_data,
   output logic [W/8-1:0]  o_rx_k,
   output logic            o_rx_dvalid,
   output logic            o_rx_valid,
   output logic            o_rx_elec_idle
);

   logic           w_pass;
   logic [W-1:0]   r_rx_data;
   logic [W/8-1:0] r_rx_k;
   logic           r_rx_dvalid;
   logic           r_rx_valid;
   logic           r_rx_elec_idle;

   assign w_pass = (i_power_down == PD_P0) && !i_tx_elec_idle;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_rx_data      <= '0;
         r_rx_k         <= '0;
         r_rx_dvalid    <= 1'b0;
         r_rx_valid     <= 1'b0;
         r_rx_elec_idle <= 1'b1;
      end else begin
         r_rx_elec_idle <= i_tx_elec_idle;
         if (w_pass) begin
            r_rx_data   <= i_tx_data;
            r_rx_k      <= i_tx_k;
            r_rx_dvalid <= i_tx_valid;
            r_rx_valid  <= 1'b1;
         end else begin
            r_rx_data   <= '0;
            r_rx_k      <= '0;
            r_rx_dvalid <= 1'b0;
            r_rx_valid  <= 1'b0;
         end
      end
   end

   assign o_rx_data      = r_rx_data;
   assign o_rx_k         = r_rx_k;
   assign o_rx_dvalid    = r_rx_dvalid;
   assign o_rx_valid     = r_rx_valid;
   assign o_rx_elec_idle = r_rx_elec_idle;

endmodule

// File: rtl/pipe_phy_stub.sv
// pipe_phy_stub
// Behavioural PIPE PHY stand-in. One control FSM shared by all lanes answers
// receiver-detect, PowerDown changes and Rate changes with a single-cycle
// PhyStatus pulse after a programmable latency; each lane loops transmit
// data back to receive through pipe_lane_loopback.
// Ports:
//   CLK, reset               clock, synchronous active-high reset
//   TxData/TxDataK/TxDataValid  controller transmit data, K flags, valid
//   TxElecIdle               per-lane transmit electrical idle
//   TxDetectRx_Loopback      per-lane receiver-detect request
//   PowerDown (4b/lane), Rate  power state and rate requests
//   RxData/RxDataK/RxDataValid/RxValid  looped-back receive side
//   RxStatus (3b/lane)       receiver-detect result (only in the result cycle)
//   RxElectricalIdle         TxElecIdle delayed one cycle
//   PhyStatus                per-lane completion pulse
module pipe_phy_stub
   import pipe_phy_stub_pkg::*;
#(
   parameter int MAXPIPEWIDTH   = 32,
   parameter int LANESNUMBER    = 16,
   parameter int DETECT_LATENCY = 16,
   parameter int PWR_LATENCY    = 4,
   parameter int RATE_LATENCY   = 8,
   parameter logic [LANESNUMBER-1:0] RX_PRESENT_MASK = '1
)(
   input  logic                                  CLK,
   input  logic                                  reset,
   input  logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   TxData,
   input  logic [LANESNUMBER-1:0]                TxDataValid,
   input  logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] TxDataK,
   input  logic [LANESNUMBER-1:0]                TxElecIdle,
   input  logic [LANESNUMBER-1:0]                TxDetectRx_Loopback,
   input  logic [4*LANESNUMBER-1:0]              PowerDown,
   input  logic [3:0]                            Rate,
   output logic [MAXPIPEWIDTH*LANESNUMBER-1:0]   RxData,
   output logic [LANESNUMBER-1:0]                RxDataValid,
   output logic [(MAXPIPEWIDTH/8)*LANESNUMBER-1:0] RxDataK,
   output logic [LANESNUMBER-1:0]                RxValid,
   output logic [3*LANESNUMBER-1:0]              RxStatus,
   output logic [LANESNUMBER-1:0]                RxElectricalIdle,
   output logic [LANESNUMBER-1:0]                PhyStatus
);

   localparam int KW = MAXPIPEWIDTH / 8;

   ctrl_state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
   logic                    r_pwr_pend, r_rate_pend;
   logic [4*LANESNUMBER-1:0] r_pd_copy;
   logic [3:0]              r_rate_copy;

   logic w_pd_chg, w_rate_chg, w_detect_req;
   logic w_take_pwr, w_take_rate;
   logic w_phy_pulse, w_det_done;

   assign w_pd_chg     = (PowerDown != r_pd_copy);
   assign w_rate_chg   = (Rate != r_rate_copy);
   assign w_detect_req = (|TxDetectRx_Loopback) && (&TxElecIdle) &&
                         (PowerDown[3:0] == PD_P1);

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_pwr_pend  <= 1'b0;
         r_rate_pend <= 1'b0;
         r_pd_copy   <= {LANESNUMBER{PD_P1}};
         r_rate_copy <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pd_copy   <= PowerDown;
         r_rate_copy <= Rate;
         // The pending flag drops when the request is accepted into its wait
         // state, so a change arriving during that wait re-arms it and gets its
         // own pulse afterwards. A new change always wins over the clear.
         r_pwr_pend  <= w_pd_chg   | (r_pwr_pend  & ~w_take_pwr);
         r_rate_pend <= w_rate_chg | (r_rate_pend & ~w_take_rate);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_take_pwr  = 1'b0;
      w_take_rate = 1'b0;
      w_phy_pulse = 1'b0;
      w_det_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_detect_req) begin
               w_state_nxt = ST_DETECT_WAIT;
               w_cnt_nxt   = lat_load(DETECT_LATENCY);
            end else if (r_pwr_pend) begin
               w_state_nxt = ST_PWR_WAIT;
               w_cnt_nxt   = lat_load(PWR_LATENCY);
               w_take_pwr  = 1'b1;
            end else if (r_rate_pend) begin
               w_state_nxt = ST_RATE_WAIT;
               w_cnt_nxt   = lat_load(RATE_LATENCY);
               w_take_rate = 1'b1;
            end
         end
         ST_DETECT_WAIT: begin
            if (r_cnt == '0) w_state_nxt = ST_DETECT_DONE;
            else             w_cnt_nxt   = r_cnt - 1'b1;
         end
         ST_DETECT_DONE: begin
            w_phy_pulse = 1'b1;
            w_det_done  = 1'b1;
            w_state_nxt = ST_DETECT_HOLD;
         end
         ST_DETECT_HOLD: begin
            if (!(|TxDetectRx_Loopback)) w_state_nxt = ST_IDLE;
         end
         ST_PWR_WAIT, ST_RATE_WAIT: begin
            // Pulse in the zero-count cycle, then fall back to IDLE, which
            // guarantees at least one quiet cycle between pulses.
            if (r_cnt == '0) begin
               w_phy_pulse = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign PhyStatus = {LANESNUMBER{w_phy_pulse}};

   for (genvar g = 0; g < LANESNUMBER; g++) begin : g_lane
      assign RxStatus[g*3 +: 3] = (w_det_done && RX_PRESENT_MASK[g]) ? RXST_RX_DET : RXST_OK;

      pipe_lane_loopback #(.W(MAXPIPEWIDTH)) u_lane (
         .i_clk          (CLK),
         .i_reset        (reset),
         .i_tx_data      (TxData[g*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
         .i_tx_k         (TxDataK[g*KW +: KW]),
         .i_tx_valid     (TxDataValid[g]),
         .i_tx_elec_idle (TxElecIdle[g]),
         .i_power_down   (PowerDown[g*4 +: 4]),
         .o_rx_data      (RxData[g*MAXPIPEWIDTH +: MAXPIPEWIDTH]),
         .o_rx_k         (RxDataK[g*KW +: KW]),
         .o_rx_dvalid    (RxDataValid[g]),
         .o_rx_valid     (RxValid[g]),
         .o_rx_elec_idle (RxElectricalIdle[g])
      );
   end

endmodule

// File: tb/tb_pipe_phy_stub.sv
// tb_pipe_phy_stub
// Directed scenarios plus randomized traffic against a timestamp-based
// reference model. Two DUTs share stimulus: one with every receiver present,
// one with only lanes 0-7 present.
module tb_pipe_phy_stub;

   localparam int W = 32, N = 16, KW = W / 8;
   localparam int DET_L = 16, PWR_L = 4, RATE_L = 8;
   localparam logic [N-1:0] MASK_B = 16'h00FF;
   localparam logic [3:0] P0 = 4'b0000, P1 = 4'b0010;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic             reset;
   logic [W*N-1:0]   TxData;
   logic [N-1:0]     TxDataValid;
   logic [KW*N-1:0]  TxDataK;
   logic [N-1:0]     TxElecIdle;
   logic [N-1:0]     TxDetectRx_Loopback;
   logic [4*N-1:0]   PowerDown;
   logic [3:0]       Rate;

   logic [W*N-1:0]   a_RxData, b_RxData;
   logic [N-1:0]     a_RxDataValid, b_RxDataValid;
   logic [KW*N-1:0]  a_RxDataK, b_RxDataK;
   logic [N-1:0]     a_RxValid, b_RxValid;
   logic [3*N-1:0]   a_RxStatus, b_RxStatus;
   logic [N-1:0]     a_RxElectricalIdle, b_RxElectricalIdle;
   logic [N-1:0]     a_PhyStatus, b_PhyStatus;

   pipe_phy_stub dut_a (
      .CLK(CLK), .reset(reset), .TxData(TxData), .TxDataValid(TxDataValid),
      .TxDataK(TxDataK), .TxElecIdle(TxElecIdle),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown), .Rate(Rate),
      .RxData(a_RxData), .RxDataValid(a_RxDataValid), .RxDataK(a_RxDataK),
      .RxValid(a_RxValid), .RxStatus(a_RxStatus),
      .RxElectricalIdle(a_RxElectricalIdle), .PhyStatus(a_PhyStatus)
   );

   pipe_phy_stub #(.RX_PRESENT_MASK(MASK_B)) dut_b (
      .CLK(CLK), .reset(reset), .TxData(TxData), .TxDataValid(TxDataValid),
      .TxDataK(TxDataK), .TxElecIdle(TxElecIdle),
      .TxDetectRx_Loopback(TxDetectRx_Loopback), .PowerDown(PowerDown), .Rate(Rate),
      .RxData(b_RxData), .RxDataValid(b_RxDataValid), .RxDataK(b_RxDataK),
      .RxValid(b_RxValid), .RxStatus(b_RxStatus),
      .RxElectricalIdle(b_RxElectricalIdle), .PhyStatus(b_PhyStatus)
   );

   int n_chk = 0, n_err = 0;
   int cyc = 0;
   int n_pulse = 0;
   bit prev_pulse = 1'b0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   // Reference model: an active event is remembered by its kind and the cycle
   // at which its PhyStatus pulse is due.
   int  mode = 0;      // 0 none, 1 detect, 2 power, 3 rate
   int  t_done = 0;
   bit  hold = 1'b0;   // detect result given, waiting for request release
   bit  pend_p = 1'b0, pend_r = 1'b0;
   logic [4*N-1:0] cpy_pd;
   logic [3:0]     cpy_rate;

   logic [N-1:0]    e_phy, e_rxdv, e_rxv, e_rxei;
   logic [3*N-1:0]  e_st_a, e_st_b;
   logic [W*N-1:0]  e_rxd;
   logic [KW*N-1:0] e_rxk;

   task automatic model_edge();
      bit det_req, chg_p, chg_r, take_p, take_r, pulse;
      cyc++;
      if (reset) begin
         mode = 0; hold = 1'b0; pend_p = 1'b0; pend_r = 1'b0;
         cpy_pd = {N{P1}}; cpy_rate = '0;
         e_phy = '0; e_st_a = '0; e_st_b = '0;
         e_rxd = '0; e_rxk = '0; e_rxdv = '0; e_rxv = '0; e_rxei = '1;
      end else begin
         det_req = (TxDetectRx_Loopback != '0) && (TxElecIdle == '1) && (PowerDown[3:0] == P1);
         chg_p = (PowerDown != cpy_pd);
         chg_r = (Rate != cpy_rate);
         take_p = 1'b0; take_r = 1'b0;
         if (mode == 0 && !hold) begin
            if (det_req) begin
               mode = 1; t_done = cyc + DET_L;
            end else if (pend_p) begin
               mode = 2; t_done = cyc + PWR_L - 1; take_p = 1'b1;
            end else if (pend_r) begin
               mode = 3; t_done = cyc + RATE_L - 1; take_r = 1'b1;
            end
         end else if (hold) begin
            if (TxDetectRx_Loopback == '0) hold = 1'b0;
         end else if (cyc == t_done + 1) begin
            if (mode == 1) hold = 1'b1;
            mode = 0;
         end
         pend_p = chg_p | (pend_p & ~take_p);
         pend_r = chg_r | (pend_r & ~take_r);
         cpy_pd = PowerDown;
         cpy_rate = Rate;

         pulse = (mode != 0) && (cyc == t_done);
         e_phy = pulse ? '1 : '0;
         for (int l = 0; l < N; l++) begin
            e_st_a[l*3 +: 3] = (pulse && mode == 1) ? 3'b011 : 3'b000;
            e_st_b[l*3 +: 3] = (pulse && mode == 1 && MASK_B[l]) ? 3'b011 : 3'b000;
            if (PowerDown[l*4 +: 4] == P0 && !TxElecIdle[l]) begin
               e_rxd[l*W +: W] = TxData[l*W +: W];
               e_rxk[l*KW +: KW] = TxDataK[l*KW +: KW];
               e_rxdv[l] = TxDataValid[l];
               e_rxv[l] = 1'b1;
            end else begin
               e_rxd[l*W +: W] = '0;
               e_rxk[l*KW +: KW] = '0;
               e_rxdv[l] = 1'b0;
               e_rxv[l] = 1'b0;
            end
         end
         e_rxei = TxElecIdle;
      end
   endtask

   task automatic compare();
      chk("PhyStatus", a_PhyStatus, e_phy);
      chk("PhyStatus_m", b_PhyStatus, e_phy);
      chk("RxStatus", a_RxStatus, e_st_a);
      chk("RxStatus_m", b_RxStatus, e_st_b);
      chk("RxData", a_RxData, e_rxd);
      chk("RxDataK", a_RxDataK, e_rxk);
      chk("RxDataValid", a_RxDataValid, e_rxdv);
      chk("RxValid", a_RxValid, e_rxv);
      chk("RxElecIdle", a_RxElectricalIdle, e_rxei);
      chk("phy_b2b", prev_pulse && (a_PhyStatus != '0), 1'b0);
      prev_pulse = (a_PhyStatus != '0);
      if (prev_pulse) n_pulse++;
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare();
   endtask

   // Steps until a PhyStatus pulse is seen; n = steps taken, -1 on timeout.
   task automatic wait_pulse(input int budget, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < budget) begin
         step();
         n++;
         seen = (a_PhyStatus != '0);
      end
      if (!seen) n = -1;
   endtask

   initial begin
      int n, saved;
      logic [31:0] r;
      reset = 1'b1; TxData = '0; TxDataValid = '0; TxDataK = '0;
      TxElecIdle = '1; TxDetectRx_Loopback = '0; PowerDown = {N{P1}}; Rate = '0;
      repeat (3) step();
      chk("rst_phy", a_PhyStatus, 16'h0);
      chk("rst_rxei", a_RxElectricalIdle, 16'hFFFF);
      chk("rst_rxst", a_RxStatus, 48'h0);

      // Receiver detect; the first step samples the request.
      reset = 1'b0;
      step();
      TxDetectRx_Loopback = 16'hFFFF;
      wait_pulse(40, n);
      chk("det_latency", n, 1 + DET_L);
      chk("det_phy", a_PhyStatus, 16'hFFFF);
      chk("det_status", a_RxStatus, 48'h6DB6_DB6D_B6DB);
      chk("det_status_m", b_RxStatus, 48'h0000_006D_B6DB);
      step();
      chk("det_one_cycle", a_PhyStatus, 16'h0);
      TxDetectRx_Loopback = '0;
      repeat (3) step();

      // PowerDown P1->P0 and Rate 0->1 together: power first, then rate.
      PowerDown = {N{P0}};
      Rate = 4'd1;
      wait_pulse(20, n);
      chk("pwr_latency", n, 1 + PWR_L);
      wait_pulse(30, n);
      chk("rate_gap", n, 1 + RATE_L);
      repeat (2) step();

      // Loopback on lane 0.
      TxElecIdle = '0;
      TxData[31:0] = 32'hA5A5_0F0F;
      TxDataValid = 16'h0001;
      step();
      chk("lb_data0", a_RxData[31:0], 32'hA5A5_0F0F);
      chk("lb_valid0", a_RxValid[0], 1'b1);
      chk("lb_dvalid0", a_RxDataValid[0], 1'b1);
      TxDataValid = '0;

      // Reset in the middle of a detect wait.
      TxElecIdle = '1;
      PowerDown = {N{P1}};
      wait_pulse(20, n);
      chk("pwr_latency2", n, 1 + PWR_L);
      repeat (3) step();
      TxDetectRx_Loopback = 16'hFFFF;
      saved = n_pulse;
      repeat (11) step();
      reset = 1'b1;
      repeat (2) step();
      chk("rst_abort", n_pulse - saved, 0);
      reset = 1'b0;
      wait_pulse(40, n);
      chk("det_after_rst", n, 1 + DET_L);
      TxDetectRx_Loopback = '0;
      repeat (3) step();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int l = 0; l < N; l++) TxData[l*W +: W] = $urandom;
         r = $urandom; TxDataValid = r[N-1:0];
         TxDataK = {$urandom, $urandom};
         if ($urandom_range(0, 19) == 0) begin
            r = $urandom;
            TxElecIdle = ($urandom_range(0, 1) == 1) ? '1 : r[N-1:0];
         end
         if ($urandom_range(0, 29) == 0) begin
            for (int l = 0; l < N; l++) begin
               case ($urandom_range(0, 3))
                  0: PowerDown[l*4 +: 4] = P0;
                  1, 2: PowerDown[l*4 +: 4] = P1;
                  default: begin r = $urandom; PowerDown[l*4 +: 4] = r[3:0]; end
               endcase
            end
         end
         if ($urandom_range(0, 39) == 0) Rate = 4'($urandom_range(0, 3));
         if ($urandom_range(0, 24) == 0) begin
            r = $urandom;
            TxDetectRx_Loopback = ($urandom_range(0, 1) == 1) ? r[N-1:0] : '0;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
